// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline types, default stage constants and action resolution
package pipe_ctrl_pkg;
  localparam int DEF_NUM_STAGES = 5;
  localparam int DEF_BR_STAGE = 2;
  typedef struct packed {
    logic pc_en;
    logic pc_redirect;
  } control_type;
  typedef enum logic [1:0] {NORMAL, LOAD_USE, REDIRECT, FROZEN} action_e;
  function automatic action_e resolve(input logic stall, input logic redir, input logic lu);
    return stall ? FROZEN : redir ? REDIRECT : lu ? LOAD_USE : NORMAL;
  endfunction
endpackage

// File: rtl/pipe_ctrl_perf_counter.sv
// perf_counter: saturating event counter with synchronous clear
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline enable/bubble/redirect control with valid tracking, perf counters and stall watchdog
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int BR_STAGE   = DEF_BR_STAGE,
  parameter int XLEN       = 32,
  parameter int CNT_W      = 32,
  parameter int MAX_STALL  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ext_stall,
  input  logic                  load_use,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_target,
  input  logic                  perf_clr,
  output logic                  pc_en,
  output logic                  pc_redirect,
  output logic [XLEN-1:0]       pc_target,
  output logic [NUM_STAGES-2:0] reg_en,
  output logic [NUM_STAGES-2:0] reg_bubble,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]      cyc_cnt,
  output logic [CNT_W-1:0]      ret_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic                  stall_timeout
);
  localparam int W = NUM_STAGES - 1;
  localparam int RW = $clog2(MAX_STALL + 1);
  // bit k-1 of reg_en/reg_bubble controls the register feeding stage k
  localparam logic [W-1:0] BR_MASK = W'((1 << BR_STAGE) - 1);
  localparam logic [W-1:0] LU_EN = ~W'(1);
  localparam logic [W-1:0] LU_BUB = W'(2);
  action_e act;
  control_type ctl;
  logic pend_v;
  logic [XLEN-1:0] pend_t;
  logic [NUM_STAGES-1:0] sv_nxt;
  logic [RW-1:0] run;
  always_comb begin
    act = resolve(ext_stall, redirect_valid | pend_v, load_use);
    ctl.pc_en = !rst && (act == NORMAL || act == REDIRECT);
    ctl.pc_redirect = !rst && act == REDIRECT;
    reg_en = (rst || act == FROZEN) ? '0 : act == LOAD_USE ? LU_EN : '1;
    reg_bubble = rst ? '0 : act == REDIRECT ? BR_MASK : act == LOAD_USE ? LU_BUB : '0;
    pc_target = (ctl.pc_redirect && redirect_valid) ? redirect_target : pend_v ? pend_t : '0;
    sv_nxt = stage_valid;
    sv_nxt[0] = 1'b1;
    for (int k = 1; k < NUM_STAGES; k++)
      if (reg_en[k-1]) sv_nxt[k] = !reg_bubble[k-1] && stage_valid[k-1];
  end
  assign pc_en = ctl.pc_en;
  assign pc_redirect = ctl.pc_redirect;
  always_ff @(posedge clk)
    if (rst) stage_valid <= '0;
    else if (!ext_stall) stage_valid <= sv_nxt;
  // redirects seen while frozen are held until the pipe can take them
  always_ff @(posedge clk)
    if (rst) begin
      pend_v <= 1'b0;
      pend_t <= '0;
    end else if (ext_stall && redirect_valid) begin
      pend_v <= 1'b1;
      pend_t <= redirect_target;
    end else if (act == REDIRECT) pend_v <= 1'b0;
  always_ff @(posedge clk)
    if (rst) begin
      run <= '0;
      stall_timeout <= 1'b0;
    end else begin
      run <= !ext_stall ? '0 : run == RW'(MAX_STALL) ? run : run + 1'b1;
      if (ext_stall && run == RW'(MAX_STALL - 1)) stall_timeout <= 1'b1;
    end
  perf_counter #(.CNT_W(CNT_W)) u_cyc (.clk, .rst, .clr(perf_clr), .inc(1'b1), .cnt(cyc_cnt));
  perf_counter #(.CNT_W(CNT_W)) u_ret (.clk, .rst, .clr(perf_clr), .inc(stage_valid[NUM_STAGES-1] && !ext_stall), .cnt(ret_cnt));
  perf_counter #(.CNT_W(CNT_W)) u_stall (.clk, .rst, .clr(perf_clr), .inc(ext_stall || act == LOAD_USE), .cnt(stall_cnt));
  perf_counter #(.CNT_W(CNT_W)) u_flush (.clk, .rst, .clr(perf_clr), .inc(act == REDIRECT), .cnt(flush_cnt));
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed table-driven bench for pipe_ctrl plus watchdog/saturation sequences
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst, ext_stall, load_use, redirect_valid, perf_clr;
  logic [31:0] redirect_target;
  logic pc_en, pc_redirect, stall_timeout;
  logic [31:0] pc_target, cyc_cnt, ret_cnt, stall_cnt, flush_cnt;
  logic [3:0] reg_en, reg_bubble;
  logic [4:0] stage_valid;
  logic pc_en2, pc_redirect2, stall_timeout2;
  logic [31:0] pc_target2;
  logic [3:0] cyc2, ret2, stl2, fl2, reg_en2, reg_bubble2;
  logic [4:0] stage_valid2;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  pipe_ctrl dut (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .load_use(load_use),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .perf_clr(perf_clr),
    .pc_en(pc_en), .pc_redirect(pc_redirect), .pc_target(pc_target), .reg_en(reg_en),
    .reg_bubble(reg_bubble), .stage_valid(stage_valid), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .stall_timeout(stall_timeout)
  );
  pipe_ctrl #(.MAX_STALL(8), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .load_use(load_use),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .perf_clr(perf_clr),
    .pc_en(pc_en2), .pc_redirect(pc_redirect2), .pc_target(pc_target2), .reg_en(reg_en2),
    .reg_bubble(reg_bubble2), .stage_valid(stage_valid2), .cyc_cnt(cyc2), .ret_cnt(ret2),
    .stall_cnt(stl2), .flush_cnt(fl2), .stall_timeout(stall_timeout2)
  );
  typedef struct packed {
    logic es, lu, rv;
    logic [31:0] tgt;
    logic pc_en, pc_red;
    logic [31:0] pc_tgt;
    logic [3:0] en, bub;
    logic [4:0] sv;
    int ret, stl, fl;
  } vec_t;
  vec_t tbl [19];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{0,0,0,32'h0,   1,0,32'h0,   4'hf,4'h0,5'b00001,0,0,0};
    tbl[1]  = '{0,0,0,32'h0,   1,0,32'h0,   4'hf,4'h0,5'b00011,0,0,0};
    tbl[2]  = '{0,0,0,32'h0,   1,0,32'h0,   4'hf,4'h0,5'b00111,0,0,0};
    tbl[3]  = '{0,0,0,32'h0,   1,0,32'h0,   4'hf,4'h0,5'b01111,0,0,0};
    tbl[4]  = '{0,0,0,32'h0,   1,0,32'h0,   4'hf,4'h0,5'b11111,0,0,0};
    tbl[5]  = '{0,0,0,32'h0,   1,0,32'h0,   4'hf,4'h0,5'b11111,1,0,0};
    tbl[6]  = '{0,1,0,32'h0,   0,0,32'h0,   4'he,4'h2,5'b11011,2,1,0};
    tbl[7]  = '{0,0,0,32'h0,   1,0,32'h0,   4'hf,4'h0,5'b10111,3,1,0};
    tbl[8]  = '{0,0,1,32'h100, 1,1,32'h100, 4'hf,4'h3,5'b01001,4,1,1};
    tbl[9]  = '{1,0,1,32'h200, 0,0,32'h0,   4'h0,4'h0,5'b01001,4,2,1};
    tbl[10] = '{1,0,0,32'h0,   0,0,32'h200, 4'h0,4'h0,5'b01001,4,3,1};
    tbl[11] = '{1,0,0,32'h0,   0,0,32'h200, 4'h0,4'h0,5'b01001,4,4,1};
    tbl[12] = '{0,0,0,32'h0,   1,1,32'h200, 4'hf,4'h3,5'b10001,4,4,2};
    tbl[13] = '{0,1,1,32'h300, 1,1,32'h300, 4'hf,4'h3,5'b00001,5,4,3};
    tbl[14] = '{0,0,0,32'h0,   1,0,32'h0,   4'hf,4'h0,5'b00011,5,4,3};
    tbl[15] = '{1,0,1,32'h400, 0,0,32'h0,   4'h0,4'h0,5'b00011,5,5,3};
    tbl[16] = '{1,0,1,32'h500, 0,0,32'h400, 4'h0,4'h0,5'b00011,5,6,3};
    tbl[17] = '{0,0,0,32'h0,   1,1,32'h500, 4'hf,4'h3,5'b00001,5,6,4};
    tbl[18] = '{0,0,0,32'h0,   1,0,32'h0,   4'hf,4'h0,5'b00011,5,6,4};
    rst = 1'b1; ext_stall = 1'b0; load_use = 1'b1; redirect_valid = 1'b0;
    redirect_target = '0; perf_clr = 1'b0;
    tick();
    tick();
    chk("rst_pc_en", pc_en, 0);
    chk("rst_reg_en", reg_en, 0);
    chk("rst_reg_bubble", reg_bubble, 0);
    chk("rst_stage_valid", stage_valid, 0);
    chk("rst_cyc", cyc_cnt, 0);
    chk("rst_timeout", stall_timeout, 0);
    rst = 1'b0;
    for (int i = 0; i < 19; i++) begin
      ext_stall = tbl[i].es; load_use = tbl[i].lu;
      redirect_valid = tbl[i].rv; redirect_target = tbl[i].tgt;
      #1;
      chk($sformatf("row%0d_pc_en", i), pc_en, tbl[i].pc_en);
      chk($sformatf("row%0d_pc_redirect", i), pc_redirect, tbl[i].pc_red);
      chk($sformatf("row%0d_pc_target", i), pc_target, tbl[i].pc_tgt);
      chk($sformatf("row%0d_reg_en", i), reg_en, tbl[i].en);
      chk($sformatf("row%0d_reg_bubble", i), reg_bubble, tbl[i].bub);
      tick();
      chk($sformatf("row%0d_stage_valid", i), stage_valid, tbl[i].sv);
      chk($sformatf("row%0d_ret_cnt", i), ret_cnt, 64'(tbl[i].ret));
      chk($sformatf("row%0d_stall_cnt", i), stall_cnt, 64'(tbl[i].stl));
      chk($sformatf("row%0d_flush_cnt", i), flush_cnt, 64'(tbl[i].fl));
    end
    ext_stall = 1'b0; load_use = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    chk("cyc_after_table", cyc_cnt, 19);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("clr_cyc", cyc_cnt, 0);
    chk("clr_ret", ret_cnt, 0);
    chk("clr_stall", stall_cnt, 0);
    chk("clr_flush", flush_cnt, 0);
    tick();
    chk("cyc_after_clr", cyc_cnt, 1);
    ext_stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h700;
    tick();
    redirect_valid = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_pc_en", pc_en, 0);
    chk("midrst_pc_redirect", pc_redirect, 0);
    chk("midrst_reg_en", reg_en, 0);
    tick();
    rst = 1'b0; ext_stall = 1'b0;
    #1;
    chk("postrst_pc_redirect", pc_redirect, 0);
    chk("postrst_pc_target", pc_target, 0);
    chk("postrst_bubble", reg_bubble, 0);
    tick();
    chk("postrst_sv0", stage_valid, 5'b00001);
    rst = 1'b1;
    tick();
    rst = 1'b0; ext_stall = 1'b1;
    repeat (7) tick();
    chk("wd_before_8", stall_timeout2, 0);
    tick();
    chk("wd_at_8", stall_timeout2, 1);
    tick();
    tick();
    ext_stall = 1'b0;
    repeat (3) tick();
    chk("wd_sticky", stall_timeout2, 1);
    chk("wd_default_quiet", stall_timeout, 0);
    rst = 1'b1;
    tick();
    chk("wd_rst_clear", stall_timeout2, 0);
    rst = 1'b0;
    repeat (20) tick();
    chk("cyc_saturate", cyc2, 15);
    chk("cyc_wide", cyc_cnt, 20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
